// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO in fixed-length bursts onto a registered valid/ready stream,
// flushing a stale partial fill as a short burst after TIMEOUT idle cycles.
module fifo_burst_reader #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 5,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    input  logic [AWIDTH:0]   fifo_usedw_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o,
    output logic              busy_o,
    output logic [15:0]       burst_cnt_o
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AWIDTH:0] BLEN    = (AWIDTH + 1)'(BURST_LEN);
    localparam logic [AWIDTH:0] REM_ONE = (AWIDTH + 1)'(1);
    localparam logic [TW-1:0]   TLAST   = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH:0]   remaining_q, remaining_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              first_q, first_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              load;
    logic              pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            timer_q     <= '0;
            first_q     <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            first_q     <= first_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        first_d     = first_q;
        data_d      = data_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        cnt_d       = cnt_q;

        // The output stage may only take a new word when it is empty or draining.
        load = !valid_q || ready_i;
        pop  = (state_q == BURST) && !fifo_empty_i && (remaining_q != '0) && load;

        if (valid_q && ready_i && eop_q)
            cnt_d = cnt_q + 16'd1;

        unique case (state_q)
            IDLE: begin
                if (fifo_usedw_i >= BLEN) begin
                    state_d     = BURST;
                    remaining_d = BLEN;
                    first_d     = 1'b1;
                    timer_d     = '0;
                end else if (timer_q == TLAST && fifo_usedw_i != '0) begin
                    state_d     = BURST;
                    remaining_d = fifo_usedw_i;
                    first_d     = 1'b1;
                    timer_d     = '0;
                end else if (fifo_usedw_i == '0) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BURST: begin
                if (pop) begin
                    remaining_d = remaining_q - 1'b1;
                    first_d     = 1'b0;
                    if (remaining_q == REM_ONE)
                        state_d = IDLE;
                end
            end
        endcase

        if (pop) begin
            data_d  = fifo_q_i;
            valid_d = 1'b1;
            sop_d   = first_q;
            eop_d   = (remaining_q == REM_ONE);
        end else if (load) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end
    end

    assign fifo_rdreq_o = pop;
    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign sop_o        = sop_q;
    assign eop_o        = eop_q;
    assign busy_o       = (state_q == BURST);
    assign burst_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-backed show-ahead FIFO, cycle reference model and
// directed burst/backpressure/timeout/reset scenarios followed by random traffic.
module tb_fifo_burst_reader;
    localparam int DW = 16, AW = 5, BL = 8, TO = 16;

    logic          clk = 1'b0, rst = 1'b0;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_empty = 1'b1;
    logic [AW:0]   fifo_usedw = '0;
    logic          hide = 1'b0;
    logic          emp_i;
    logic          rdreq, valid, sop, eop, busy;
    logic          ready = 1'b1;
    logic [DW-1:0] data;
    logic [15:0]   bcnt;

    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] fq[$];
    logic [17:0]   log_q[$];
    int            log_cyc[$];
    int            cyc = 0;
    bit            bp = 0, rnd = 0;
    int            total = 0, bad = 0;

    // reference model state
    bit            m_burst = 0, m_first = 0, m_vld = 0, m_sop = 0, m_eop = 0;
    int            m_left = 0, m_wait = 0, m_cnt = 0;
    logic [DW-1:0] m_data = '0;
    bit            p_pop, p_was;
    int            p_used;

    assign emp_i = fifo_empty | hide;

    fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .fifo_q_i(fifo_q), .fifo_empty_i(emp_i),
        .fifo_usedw_i(fifo_usedw), .fifo_rdreq_o(rdreq), .data_o(data), .valid_o(valid),
        .ready_i(ready), .sop_o(sop), .eop_o(eop), .busy_o(busy), .burst_cnt_o(bcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_rd();
        return m_burst && !emp_i && (m_left > 0) && (!m_vld || ready);
    endfunction

    // FIFO storage and reference model advance together on each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_burst = 0; m_first = 0; m_vld = 0; m_sop = 0; m_eop = 0;
            m_left = 0; m_wait = 0; m_cnt = 0; m_data = '0;
        end else begin
            p_pop  = m_rd();
            p_was  = m_burst;
            p_used = int'(fifo_usedw);
            if (m_vld && ready && m_eop) m_cnt = (m_cnt + 1) % 65536;
            if (p_pop) begin
                m_data  = fifo_q;
                m_vld   = 1;
                m_sop   = m_first;
                m_eop   = (m_left == 1);
                m_first = 0;
                m_left  = m_left - 1;
                if (m_left == 0) m_burst = 0;
            end else if (!m_vld || ready) begin
                m_vld = 0; m_sop = 0; m_eop = 0;
            end
            if (!p_was) begin
                if (p_used >= BL) begin
                    m_burst = 1; m_left = BL; m_first = 1; m_wait = 0;
                end else if (p_used != 0 && m_wait == TO - 1) begin
                    m_burst = 1; m_left = p_used; m_first = 1; m_wait = 0;
                end else if (p_used == 0) m_wait = 0;
                else m_wait = m_wait + 1;
            end
            if (rdreq && fq.size() > 0) void'(fq.pop_front());
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
            fifo_usedw <= (AW + 1)'(fq.size());
            fifo_q     <= (fq.size() > 0) ? fq[0] : 16'hDEAD;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("rdreq", 32'(rdreq), 32'(m_rd()));
            chk("valid", 32'(valid), 32'(m_vld));
            chk("busy", 32'(busy), 32'(m_burst));
            chk("burst_cnt", 32'(bcnt), 32'(m_cnt[15:0]));
            if (m_vld) begin
                chk("data", 32'(data), 32'(m_data));
                chk("sop", 32'(sop), 32'(m_sop));
                chk("eop", 32'(eop), 32'(m_eop));
            end
            if (valid && !ready) chk("rdreq_under_bp", 32'(rdreq), 32'(0));
            if (valid && ready) begin
                log_q.push_back({sop, eop, data});
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (bp) ready = !ready;
        if (rnd) begin
            ready   = ($urandom_range(0, 3) != 0);
            hide    = ($urandom_range(0, 7) == 0);
            wr_en   = (fq.size() < 28) && ($urandom_range(0, 2) == 0);
            wr_data = 16'($urandom);
        end
    endtask

    task automatic push(int n, logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 16'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_log(string nm, int n, int budget);
        int c = 0;
        while (log_q.size() < n && c < budget) begin
            step();
            c++;
        end
        chk({nm, "_timeout"}, 32'(log_q.size() >= n), 32'(1));
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic check_burst(string nm, int n, int blen, logic [15:0] base, bit contig);
        chk({nm, "_len"}, 32'(log_q.size()), 32'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            chk({nm, "_data"}, 32'(log_q[i][15:0]), 32'(base + 16'(i)));
            chk({nm, "_sop"}, 32'(log_q[i][17]), 32'(i % blen == 0));
            chk({nm, "_eop"}, 32'(log_q[i][16]), 32'((i % blen == blen - 1) || (i == n - 1)));
            if (contig) chk({nm, "_gap"}, 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end
    endtask

    initial begin
        int n;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_data", 32'(data), 32'(0));
        chk("rst_sop", 32'(sop), 32'(0));
        chk("rst_eop", 32'(eop), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cnt", 32'(bcnt), 32'(0));
        chk("rst_rdreq", 32'(rdreq), 32'(0));
        step(); step();
        #2 rst = 1'b0;
        step();

        // full burst, no backpressure
        clear_log();
        push(8, 16'h0001);
        wait_log("full", 8, 40);
        step();
        check_burst("full", 8, 8, 16'h0001, 1);
        chk("full_cnt", 32'(bcnt), 32'(1));

        // alternating ready: two full bursts
        clear_log();
        bp = 1;
        push(16, 16'h0100);
        wait_log("bp", 16, 200);
        bp = 0;
        ready = 1'b1;
        step();
        check_burst("bp", 16, 8, 16'h0100, 0);
        chk("bp_cnt", 32'(bcnt), 32'(3));

        // partial fill flushed by the timeout
        clear_log();
        push(3, 16'h00A0);
        n = 0;
        while (!busy && n < 40) begin
            step();
            n++;
        end
        chk("tmo_latency", 32'(n), 32'(14));
        wait_log("tmo", 3, 40);
        step();
        check_burst("tmo", 3, 8, 16'h00A0, 1);
        chk("tmo_cnt", 32'(bcnt), 32'(4));

        // fill reaches BURST_LEN on the same cycle the timer expires
        clear_log();
        push(1, 16'h00C0);
        for (int i = 0; i < 8; i++) step();
        push(7, 16'h00C1);
        chk("prec_idle", 32'(busy), 32'(0));
        step();
        chk("prec_busy", 32'(busy), 32'(1));
        wait_log("prec", 8, 40);
        step();
        check_burst("prec", 8, 8, 16'h00C0, 1);
        chk("prec_cnt", 32'(bcnt), 32'(5));

        // async reset after the 4th accepted word
        clear_log();
        push(8, 16'h00D1);
        wait_log("rst4", 4, 40);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_cnt", 32'(bcnt), 32'(0));
        chk("arst_rdreq", 32'(rdreq), 32'(0));
        chk("arst_sop", 32'(sop), 32'(0));
        chk("arst_eop", 32'(eop), 32'(0));
        step(); step();
        chk("arst_hold_rdreq", 32'(rdreq), 32'(0));
        clear_log();
        #2 rst = 1'b0;
        wait_log("post", 3, 60);
        step();
        check_burst("post", 3, 8, 16'h00D6, 1);
        chk("post_cnt", 32'(bcnt), 32'(1));

        // random traffic, readiness and empty-flag lag
        rnd = 1;
        for (int i = 0; i < 3000; i++) step();
        rnd = 0;
        wr_en = 1'b0;
        hide = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 200; i++) step();
        chk("drain_fifo_empty", 32'(fq.size()), 32'(0));
        chk("drain_idle", 32'(busy | valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
